alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational ALU instance between two requesters with valid/ready handshakes.
//  Typical requesters: req0 = main execute path, req1 = address/branch-compare helper.
//  Arbitrates round-robin, drives the ALU operand/control inputs from the winner,
//  and registers the ALU result into a one-entry response slot tagged with the requester id.
//  Sits between the requesters and the alu instance (preSrcA/preSrcB/ALUControl/Sub in; ALUResult/Zero out).
// PARAMETERS
//  WIDTH    32  operand/result width; must match the ALU datapath width
//  CNT_W    16  width of the completed-operation counter
// PORTS
//  clk          in   1      clock; all state updates on rising edge
//  reset        in   1      synchronous, active-high reset
//  req0_valid   in   1      requester 0 has an operation
//  req0_ready   out  1      requester 0 operation accepted this cycle when valid&ready
//  req0_a       in   WIDTH  requester 0 operand A
//  req0_b       in   WIDTH  requester 0 operand B
//  req0_ctrl    in   3      requester 0 ALUControl code
//  req0_sub     in   1      requester 0 Sub (invert B, +1)
//  req1_*       -    -      same five signals for requester 1
//  alu_a        out  WIDTH  to ALU preSrcA
//  alu_b        out  WIDTH  to ALU preSrcB
//  alu_ctrl     out  3      to ALU ALUControl
//  alu_sub      out  1      to ALU Sub
//  alu_result   in   WIDTH  from ALU ALUResult
//  alu_zero     in   1      from ALU Zero
//  rsp_valid    out  1      response slot holds a result
//  rsp_ready    in   1      consumer takes the response when rsp_valid&rsp_ready
//  rsp_id       out  1      requester that owns the response (0/1)
//  rsp_result   out  WIDTH  registered ALU result
//  rsp_zero     out  1      registered ALU Zero flag
//  op_count     out  CNT_W  number of accepted operations since reset
// BEHAVIOUR
//  - slot_free = !rsp_valid | rsp_ready; no request accepted when slot_free=0.
//  - Grant (combinational): only one valid -> it wins; both valid -> requester != last_grant wins.
//  - reqN_ready = slot_free & grant==N; at most one ready high per cycle; ready may depend on valid.
//  - ALU inputs are muxed combinationally from the granted requester;
//    all-zero (a=0, b=0, ctrl=000, sub=0) when there is no grant.
//  - Accept (valid&ready): next edge loads rsp_result=alu_result, rsp_zero=alu_zero, rsp_id=N,
//    sets rsp_valid=1, last_grant=N, and increments op_count.
//  - Latency: accept in cycle T -> response visible in cycle T+1. Throughput: 1 op/cycle while rsp_ready=1.
//  - rsp_valid&!rsp_ready: response registers are held stable and both readies are 0 (backpressure).
//  - rsp_valid&rsp_ready with no accept in the same cycle: rsp_valid clears next edge.
//  - Simultaneous drain + accept in one cycle: the new result replaces the old; rsp_valid stays 1.
//  - last_grant changes only on accept. Idle cycles do not move the round-robin pointer.
//  - op_count wraps modulo 2^CNT_W (all-ones + 1 -> 0).
//  - Requesters must hold operands stable while valid&!ready. The arbiter does not buffer requests.
//  - Reset (synchronous, takes priority, including mid-backpressure):
//    rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, op_count=0, last_grant=1 (req0 wins first tie).
//    In-flight response is discarded.
// TESTING
//  1. Reset, then req0 {a=5, b=3, ctrl=000, sub=1} alone -> req0_ready=1; next cycle rsp_valid=1, id=0, result=2, zero=0, op_count=1.
//  2. Both valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1 one cycle later.
//  3. rsp_ready=0 for 3 cycles with both valid -> readies 0, rsp_* frozen; on release a single accept follows the round-robin order.
//  4. req1 {a=7, b=7, ctrl=000, sub=1} -> rsp_result=0, rsp_zero=1, rsp_id=1.
//  5. Assert reset while rsp_valid=1 & rsp_ready=0 -> next cycle all outputs at reset values; first tie goes to req0.
//  6. Preload CNT_W=4 via 15 accepts, then one more accept -> op_count wraps 15->0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Purpose : shares one combinational ALU between two valid/ready requesters, round-robin on ties.
// Latency : an operation accepted in cycle T shows up in the response slot in cycle T+1; 1 op/cycle sustained.
// Backpressure: a held response (rsp_valid & !rsp_ready) drops both readies and freezes the slot.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req{0,1}_valid/_ready      request handshake per requester
//   req{0,1}_a/_b/_ctrl/_sub   operands and ALU control of each requester
//   alu_a/_b/_ctrl/_sub        operands/control driven to the shared ALU
//   alu_result/_zero           combinational ALU outputs
//   rsp_valid/_ready           one-entry response slot handshake
//   rsp_id/_result/_zero       owner and registered ALU outputs of the held response
//   op_count                   accepted operations since reset, wraps modulo 2^CNT_W
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_ctrl,
    input  logic             req0_sub,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_ctrl,
    input  logic             req1_sub,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    output logic             alu_sub,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic [CNT_W-1:0] op_count
);

    // Contents of the response slot, kept together so load/hold/reset act on one bus.
    typedef struct packed {
        logic             id;
        logic             zero;
        logic [WIDTH-1:0] result;
    } rsp_t;

    rsp_t             rsp_q;
    logic             rsp_valid_q;
    logic             last_grant_q;
    logic [CNT_W-1:0] op_count_q;

    logic slot_free;
    logic grant_vld;
    logic grant_id;
    logic accept;

    // The slot can take a new result if it is empty or being drained this cycle.
    assign slot_free = !rsp_valid_q || rsp_ready;

    // A lone requester always wins; on a tie the one not served last wins.
    always_comb begin
        grant_vld = req0_valid || req1_valid;
        grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant_q;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    assign accept     = grant_vld && slot_free;
    assign req0_ready = accept && (grant_id == 1'b0);
    assign req1_ready = accept && (grant_id == 1'b1);

    // The ALU sees the granted requester even while the slot is blocked, so its
    // result is already settled when the slot frees up; zeros when nobody asks.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = 3'b000;
        alu_sub  = 1'b0;
        if (grant_vld) begin
            if (grant_id) begin
                alu_a    = req1_a;
                alu_b    = req1_b;
                alu_ctrl = req1_ctrl;
                alu_sub  = req1_sub;
            end else begin
                alu_a    = req0_a;
                alu_b    = req0_b;
                alu_ctrl = req0_ctrl;
                alu_sub  = req0_sub;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_q        <= '0;
            rsp_valid_q  <= 1'b0;
            // Pointing at requester 1 makes requester 0 win the first tie.
            last_grant_q <= 1'b1;
            op_count_q   <= '0;
        end else begin
            if (accept) begin
                // Covers the drain+accept case too: the new result overwrites the old.
                rsp_q.id     <= grant_id;
                rsp_q.zero   <= alu_zero;
                rsp_q.result <= alu_result;
                rsp_valid_q  <= 1'b1;
                last_grant_q <= grant_id;
                op_count_q   <= op_count_q + 1'b1;
            end else if (rsp_ready) begin
                // Drained with nothing new: only the valid bit drops, data is left as is.
                rsp_valid_q  <= 1'b0;
            end
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_q.id;
    assign rsp_zero   = rsp_q.zero;
    assign rsp_result = rsp_q.result;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Purpose : directed, table-driven check of alu_share_arbiter with a small ALU model attached.
// Latency : response checked one edge after each applied vector.
// Backpressure: rsp_ready is driven per vector to exercise hold, drain and drain+accept.
module tb_alu_share_arbiter;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]       req0_ctrl, req1_ctrl;
    logic             req0_sub, req1_sub;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [2:0]       alu_ctrl;
    logic             alu_sub;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_zero;
    logic [WIDTH-1:0] rsp_result;
    logic [CNT_W-1:0] op_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ctrl(req0_ctrl), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ctrl(req1_ctrl), .req1_sub(req1_sub),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_sub(alu_sub),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .op_count(op_count)
    );

    // Stand-in for the shared ALU: add/sub, and, or.
    always_comb begin
        case (alu_ctrl)
            3'b000:  alu_result = alu_a + (alu_sub ? ~alu_b : alu_b) + {31'd0, alu_sub};
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            default: alu_result = alu_a ^ alu_b;
        endcase
        alu_zero = (alu_result == '0);
    end

    typedef struct {
        logic        v0, v1;
        logic [31:0] a0, b0; logic [2:0] c0; logic s0;
        logic [31:0] a1, b1; logic [2:0] c1; logic s1;
        logic        rr;
        logic        chk_alu;
        logic        e_r0, e_r1;
        logic [31:0] e_alu_a;
        logic        e_vld;
        logic        chk_dat;
        logic        e_id;
        logic [31:0] e_res;
        logic        e_zero;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0; req0_ctrl = v.c0; req0_sub = v.s0;
        req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1; req1_ctrl = v.c1; req1_sub = v.s1;
        rsp_ready  = v.rr;
    endtask

    task automatic chk_rsp(input string tag, input logic vld, input logic id,
                           input logic [31:0] res, input logic zero, input logic [3:0] cnt);
        chk({tag, ".rsp_valid"},  {31'd0, rsp_valid}, {31'd0, vld});
        chk({tag, ".rsp_id"},     {31'd0, rsp_id},    {31'd0, id});
        chk({tag, ".rsp_result"}, rsp_result,         res);
        chk({tag, ".rsp_zero"},   {31'd0, rsp_zero},  {31'd0, zero});
        chk({tag, ".op_count"},   {28'd0, op_count},  {28'd0, cnt});
    endtask

    initial begin
        vec_t v;
        logic [3:0] exp_cnt;

        //          v0 v1  a0  b0 c0 s0  a1 b1 c1 s1 rr ca r0 r1 alu vld cd id res zr cnt
        vecs[0]  = '{1, 0,  5,  3, 0, 1,  0, 0, 0, 0, 1, 1, 1, 0,  5,  1, 1, 0,  2, 0, 1};
        vecs[1]  = '{1, 1, 10,  4, 0, 0,  7, 7, 0, 1, 1, 1, 0, 1,  7,  1, 1, 1,  0, 1, 2};
        vecs[2]  = '{1, 1, 10,  4, 0, 0,  7, 7, 0, 1, 1, 1, 1, 0, 10,  1, 1, 0, 14, 0, 3};
        vecs[3]  = '{1, 1, 10,  4, 0, 0,  7, 7, 0, 1, 1, 1, 0, 1,  7,  1, 1, 1,  0, 1, 4};
        vecs[4]  = '{1, 1, 10,  4, 0, 0,  7, 7, 0, 1, 1, 1, 1, 0, 10,  1, 1, 0, 14, 0, 5};
        vecs[5]  = '{1, 1, 10,  4, 0, 0,  7, 7, 0, 1, 0, 0, 0, 0,  0,  1, 1, 0, 14, 0, 5};
        vecs[6]  = '{1, 1, 10,  4, 0, 0,  7, 7, 0, 1, 0, 0, 0, 0,  0,  1, 1, 0, 14, 0, 5};
        vecs[7]  = '{1, 1, 10,  4, 0, 0,  7, 7, 0, 1, 0, 0, 0, 0,  0,  1, 1, 0, 14, 0, 5};
        vecs[8]  = '{1, 1, 10,  4, 0, 0,  7, 7, 0, 1, 1, 1, 0, 1,  7,  1, 1, 1,  0, 1, 6};
        vecs[9]  = '{0, 1,  0,  0, 0, 0,  7, 7, 0, 1, 1, 1, 0, 1,  7,  1, 1, 1,  0, 1, 7};
        vecs[10] = '{0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 1, 1, 0, 0,  0,  0, 0, 0,  0, 0, 7};
        vecs[11] = '{0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 1, 0, 0,  0,  0, 0, 0,  0, 0, 7};
        vecs[12] = '{1, 1, 10,  4, 0, 0,  7, 7, 0, 1, 0, 1, 1, 0, 10,  1, 1, 0, 14, 0, 8};
        vecs[13] = '{1, 0, 12, 10, 2, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0,  1, 1, 0, 14, 0, 8};
        vecs[14] = '{1, 0, 12, 10, 2, 0,  0, 0, 0, 0, 1, 1, 1, 0, 12,  1, 1, 0,  8, 0, 9};

        // Reset with everything idle.
        v = '{default: '0};
        drive(v);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_rsp("reset", 1'b0, 1'b0, 32'd0, 1'b0, 4'd0);
        chk("reset.req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("reset.alu_a", alu_a, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vecs[i]);
            #1;
            chk({tag, ".req0_ready"}, {31'd0, req0_ready}, {31'd0, vecs[i].e_r0});
            chk({tag, ".req1_ready"}, {31'd0, req1_ready}, {31'd0, vecs[i].e_r1});
            if (vecs[i].chk_alu)
                chk({tag, ".alu_a"}, alu_a, vecs[i].e_alu_a);
            @(posedge clk);
            #1;
            chk({tag, ".rsp_valid"}, {31'd0, rsp_valid}, {31'd0, vecs[i].e_vld});
            chk({tag, ".op_count"},  {28'd0, op_count},  {28'd0, vecs[i].e_cnt});
            if (vecs[i].chk_dat) begin
                chk({tag, ".rsp_id"},     {31'd0, rsp_id},   {31'd0, vecs[i].e_id});
                chk({tag, ".rsp_result"}, rsp_result,        vecs[i].e_res);
                chk({tag, ".rsp_zero"},   {31'd0, rsp_zero}, {31'd0, vecs[i].e_zero});
            end
        end

        // Reset while a response is held under backpressure.
        v = vecs[5];
        drive(v);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_rsp("rst_bp", 1'b0, 1'b0, 32'd0, 1'b0, 4'd0);
        reset = 1'b0;
        v.rr = 1'b1;
        drive(v);
        #1;
        chk("rst_bp.tie_r0", {31'd0, req0_ready}, 32'd1);
        chk("rst_bp.tie_r1", {31'd0, req1_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk_rsp("rst_bp.first", 1'b1, 1'b0, 32'd14, 1'b0, 4'd1);

        // Counter wrap: requester 0 alone, one accept per cycle.
        v.v1 = 1'b0;
        drive(v);
        exp_cnt = 4'd1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            exp_cnt = exp_cnt + 4'd1;
            if (i == 13)
                chk("wrap.at15", {28'd0, op_count}, 32'd15);
        end
        chk("wrap.model", {28'd0, exp_cnt}, 32'd0);
        chk_rsp("wrap.to0", 1'b1, 1'b0, 32'd14, 1'b0, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
